fifo_packer: RTL and testbench

- Drain stage directly downstream of the synchronous FIFO.
- Pops WIDTH-bit words through the FIFO read port and packs PACK words into one wide beat.
- Presents each beat on a valid/ready interface to the wide consumer.
- A timeout or an explicit flush closes a partially filled beat so trailing data is never stranded.

---
 rtl/fifo_packer.sv | 114 +++++++++++
 tb/tb_fifo_packer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// rtl/fifo_packer.sv - drains a synchronous FIFO and packs PACK words into one wide valid/ready beat
// Partial beats are closed by an idle timeout or an explicit flush.
module fifo_packer #(
   parameter int WIDTH   = 8,
   parameter int PACK    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        fifo_data,
   input  logic                    fifo_empty,
   output logic                    fifo_rd_en,
   input  logic                    flush,
   output logic [WIDTH*PACK-1:0]   out_data,
   output logic [PACK-1:0]         out_keep,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             pkt_count
);

   localparam int LW = $clog2(PACK + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [LW:0]   PACK_C    = PACK[LW:0];
   localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);
   localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                  state;
   logic [LW-1:0]           lanes;
   logic                    rd_pending;
   logic [TW-1:0]           timer;
   logic [WIDTH*PACK-1:0]   acc;
   logic [WIDTH*PACK-1:0]   acc_next;
   logic [PACK-1:0]         part_keep;
   logic [LW:0]             in_flight;
   logic                    partial_close;

   // Count the word still in flight so the beat never over-subscribes its lanes.
   always_comb begin
      in_flight  = {1'b0, lanes} + {{LW{1'b0}}, rd_pending};
      fifo_rd_en = ~rst & (state == FILL) & ~fifo_empty & (in_flight < PACK_C);
   end

   always_comb begin
      acc_next = acc;
      for (int k = 0; k < PACK; k++) begin
         if (lanes == LW'(k)) acc_next[k*WIDTH +: WIDTH] = fifo_data;
      end
      part_keep = '0;
      for (int k = 0; k < PACK; k++) begin
         part_keep[k] = (LW'(k) < lanes);
      end
      partial_close = (state == FILL) && (lanes != '0) && !rd_pending && fifo_empty &&
                      (flush || (timer == TIMER_LIM));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         lanes      <= '0;
         rd_pending <= 1'b0;
         timer      <= '0;
         acc        <= '0;
         out_data   <= '0;
         out_keep   <= '0;
         out_valid  <= 1'b0;
         pkt_count  <= '0;
      end else begin
         rd_pending <= fifo_rd_en & ~fifo_empty;
         case (state)
            FILL: begin
               if (rd_pending) begin
                  timer <= '0;
                  lanes <= lanes + LW'(1);
                  if (lanes == LAST_LANE) begin
                     out_data  <= acc_next;
                     out_keep  <= '1;
                     out_valid <= 1'b1;
                     acc       <= '0;
                     state     <= HOLD;
                  end else begin
                     acc <= acc_next;
                  end
               end else if (partial_close) begin
                  // acc is cleared on every close, so unused lanes are already zero.
                  out_data  <= acc;
                  out_keep  <= part_keep;
                  out_valid <= 1'b1;
                  acc       <= '0;
                  state     <= HOLD;
               end else if (lanes == '0) begin
                  timer <= '0;
               end else if (timer != TIMER_LIM) begin
                  timer <= timer + TW'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_keep  <= '0;
                  out_data  <= '0;
                  lanes     <= '0;
                  timer     <= '0;
                  pkt_count <= pkt_count + 16'd1;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_packer.sv
// tb/tb_fifo_packer.sv - directed table-driven bench for fifo_packer with a registered-read FIFO model
module tb_fifo_packer;

   localparam int WIDTH   = 8;
   localparam int PACK    = 4;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [WIDTH-1:0]      fifo_data;
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic                  flush;
   logic [WIDTH*PACK-1:0] out_data;
   logic [PACK-1:0]       out_keep;
   logic                  out_valid;
   logic                  out_ready;
   logic [15:0]           pkt_count;

   int checks = 0;
   int errors = 0;

   fifo_packer #(.WIDTH(WIDTH), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .flush(flush),
      .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // FIFO model: a pop requested in one cycle presents its word after that edge.
   logic [7:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int cyc = 0;
   int last_pop = 0;
   int pops = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= 0;
         fifo_data <= '0;
         pops      <= 0;
      end else if (fifo_rd_en && !fifo_empty) begin
         fifo_data <= mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
         last_pop  <= cyc;
         pops      <= pops + 1;
      end
   end

   int rd_while_empty = 0;
   int run = 0;
   int max_run = 0;
   always @(negedge clk) begin
      if (fifo_rd_en && fifo_empty) rd_while_empty <= rd_while_empty + 1;
      if (rst) begin
         run     <= 0;
         max_run <= 0;
      end else begin
         run <= fifo_rd_en ? run + 1 : 0;
         if (fifo_rd_en && (run + 1 > max_run)) max_run <= run + 1;
      end
   end

   logic [35:0] beat_q [$];
   always @(posedge clk or posedge rst) begin
      if (rst) beat_q.delete();
      else if (out_valid && out_ready) beat_q.push_back({out_keep, out_data});
   end

   typedef struct {
      int          n;
      logic [31:0] words;
      bit          use_flush;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
      int          exp_lat;
   } vec_t;

   vec_t vec [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_ptr % 64] = w;
      wr_ptr++;
   endtask

   task automatic start_reset();
      rst    = 1'b1;
      flush  = 1'b0;
      wr_ptr = 0;
      @(negedge clk);
   endtask

   task automatic end_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_reset();
      start_reset();
      end_reset();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (out_valid) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic wait_beats(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (beat_q.size() >= n) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      bit stable;
      bit seen;
      int lat;

      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      vec[0] = '{4, 32'h14131211, 1'b0, 32'h14131211, 4'hF, 0};
      vec[1] = '{2, 32'h0000A2A1, 1'b0, 32'h0000A2A1, 4'h3, TIMEOUT};
      vec[2] = '{1, 32'h0000005C, 1'b1, 32'h0000005C, 4'h1, 1};
      vec[3] = '{3, 32'h00030201, 1'b0, 32'h00030201, 4'h7, TIMEOUT};
      vec[4] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'hF, 0};
      vec[5] = '{2, 32'h0000FF00, 1'b1, 32'h0000FF00, 4'h3, 1};

      // Reset state, with a word waiting so fifo_rd_en would otherwise rise.
      push(8'h99);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_keep", out_keep, 0);
      check("rst_out_data", out_data, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_rd_en", fifo_rd_en, 0);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         out_ready = 1'b1;
         for (int k = 0; k < vec[v].n; k++) push(vec[v].words[k*8 +: 8]);
         if (vec[v].use_flush) begin
            repeat (vec[v].n + 1) @(negedge clk);
            flush = 1'b1;
         end
         wait_valid(ok);
         check($sformatf("v%0d_valid", v), ok, 1);
         lat   = cyc - 1 - (last_pop + 1);
         flush = 1'b0;
         check($sformatf("v%0d_data", v), out_data, vec[v].exp_data);
         check($sformatf("v%0d_keep", v), out_keep, vec[v].exp_keep);
         check($sformatf("v%0d_latency", v), lat, vec[v].exp_lat);
         @(negedge clk);
         check($sformatf("v%0d_accepted", v), out_valid, 0);
         check($sformatf("v%0d_pkt_count", v), pkt_count, 1);
      end

      // Two back-to-back full beats from a preloaded FIFO.
      start_reset();
      for (int k = 0; k < 8; k++) push(8'h11 + 8'(k));
      out_ready = 1'b1;
      end_reset();
      wait_beats(2, ok);
      check("full_two_beats", ok, 1);
      if (ok) begin
         check("full_beat0", beat_q[0], {4'hF, 32'h14131211});
         check("full_beat1", beat_q[1], {4'hF, 32'h18171615});
      end
      @(negedge clk);
      check("full_pkt_count", pkt_count, 2);
      check("full_rd_run", max_run, 4);
      check("full_pops", pops, 8);

      // Backpressure: first beat held for 10 cycles.
      start_reset();
      for (int k = 0; k < 8; k++) push(8'h11 + 8'(k));
      out_ready = 1'b0;
      end_reset();
      wait_valid(ok);
      check("bp_valid", ok, 1);
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (out_data !== 32'h14131211 || out_keep !== 4'hF || fifo_rd_en !== 1'b0 || out_valid !== 1'b1)
            stable = 1'b0;
      end
      check("bp_hold_stable", stable, 1);
      out_ready = 1'b1;
      wait_beats(2, ok);
      check("bp_two_beats", ok, 1);
      if (ok) begin
         check("bp_beat0", beat_q[0], {4'hF, 32'h14131211});
         check("bp_beat1", beat_q[1], {4'hF, 32'h18171615});
      end
      @(negedge clk);
      check("bp_pkt_count", pkt_count, 2);
      check("bp_fifo_drained", fifo_empty, 1);

      // FIFO runs dry after 3 pops; the fourth word arrives before the timeout.
      do_reset();
      out_ready = 1'b1;
      push(8'h21); push(8'h22); push(8'h23);
      repeat (5) @(negedge clk);
      check("empty_no_early_close", out_valid, 0);
      push(8'h24);
      wait_valid(ok);
      check("empty_valid", ok, 1);
      check("empty_data", out_data, 32'h24232221);
      check("empty_keep", out_keep, 4'hF);
      @(negedge clk);
      check("empty_pkt_count", pkt_count, 1);

      // Flush with no lanes filled must not produce a beat.
      do_reset();
      flush = 1'b1;
      seen  = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      flush = 1'b0;
      check("idle_flush_no_beat", seen, 0);
      check("idle_flush_pkt_count", pkt_count, 0);

      // Async reset while a beat is held.
      start_reset();
      push(8'h41); push(8'h42); push(8'h43); push(8'h44);
      out_ready = 1'b0;
      end_reset();
      wait_valid(ok);
      check("ar_hold_data_pre", out_data, 32'h44434241);
      #2;
      rst    = 1'b1;
      wr_ptr = 0;
      #1;
      check("ar_hold_valid", out_valid, 0);
      check("ar_hold_keep", out_keep, 0);
      check("ar_hold_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;

      // Async reset after two captures of a second beat.
      out_ready = 1'b1;
      push(8'h41); push(8'h42); push(8'h43); push(8'h44);
      wait_valid(ok);
      @(negedge clk);
      check("ar_pkt_count_pre", pkt_count, 1);
      for (int k = 0; k < 5; k++) push(8'h51 + 8'(k));
      repeat (3) @(negedge clk);
      check("ar_rd_en_pre", fifo_rd_en, 1);
      #2;
      rst    = 1'b1;
      wr_ptr = 0;
      #1;
      check("ar_pkt_count", pkt_count, 0);
      check("ar_rd_en", fifo_rd_en, 0);
      check("ar_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      wait_valid(ok);
      check("ar_next_valid", ok, 1);
      check("ar_next_data", out_data, 32'h64636261);
      check("ar_next_keep", out_keep, 4'hF);
      @(negedge clk);

      check("rd_en_while_empty", rd_while_empty, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
